fault_divergence_monitor: RTL and testbench

- Sits directly downstream of the golden/faulty dual single-cycle processor top.
- Samples the golden and faulty PC/Result streams every clock during a bounded run.
- Detects and records the first divergence, counts all mismatching cycles, and classifies the injected fault at the end of the run: masked, silent data corruption, or control-flow error.

---
 rtl/fault_mon_pkg.sv | 27 ++
 rtl/mismatch_log_fifo.sv | 74 +++++++
 rtl/fault_divergence_monitor.sv | 187 ++++++++++++++++++
 tb/tb_fault_divergence_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_mon_pkg.sv
// Shared types for the golden/faulty divergence monitor.
//   state_e     : run-control FSM states
//   verdict_e   : end-of-run fault classification
//   log_entry_t : fixed-width part of a mismatch log record; the
//                 CNT_W-bit sample index is prepended by the top level
package fault_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    V_NONE   = 2'b00,
    V_MASKED = 2'b01,
    V_SDC    = 2'b10,
    V_CFE    = 2'b11
  } verdict_e;

  typedef struct packed {
    logic        pc_mis;
    logic        res_mis;
    logic [31:0] pc_faulty;
  } log_entry_t;

endpackage

// File: rtl/mismatch_log_fifo.sv
// Synchronous valid/ready FIFO holding mismatch log records.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous flush (empties FIFO, clears overflow)
//   push      : write request with push_data
//   ready     : consumer ready; head pops on valid & ready
//   valid     : FIFO non-empty, data is the head entry
//   overflow  : sticky, set when a push is dropped
// A push into a full FIFO is accepted if a pop happens in the same cycle.
module mismatch_log_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, full, pop, wr_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (pop)                   rd_d  = rd_q + 1'b1;
      if (wr_en)                 wr_d  = wr_q + 1'b1;
      if (push && full && !pop)  ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_q[AW-1:0]] <= push_data;
  end

  assign valid    = !empty;
  assign data     = mem[rd_q[AW-1:0]];
  assign overflow = ovf_q;

endmodule

// File: rtl/fault_divergence_monitor.sv
// Compares golden and faulty processor PC/Result streams over a bounded
// run, records the first divergence, counts mismatching samples and
// classifies the fault (masked / SDC / CFE) when the run ends.
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse; starts a run from IDLE or DONE
//   pc_*/result_*       : golden and faulty streams, sampled each RUN edge
//   busy / done         : in RUN / in DONE
//   fault_detected      : sticky, first mismatch of the run seen
//   verdict             : 00 none, 01 masked, 10 SDC, 11 CFE (valid in DONE)
//   mismatch_count      : saturating count of mismatching samples
//   first_*             : sample index and values at the first mismatch
// Optional feature, macro FAULT_MON_LOG_EN: adds log_valid/log_ready/
// log_data/log_overflow and a LOG_DEPTH FIFO of {k, pc_mis, res_mis,
// pc_faulty} records, one per mismatching sample.
module fault_divergence_monitor
  import fault_mon_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int MAX_CYCLES    = 1024,
  parameter int STOP_ON_FIRST = 0,
  parameter int LOG_DEPTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      pc_golden,
  input  logic [31:0]      result_golden,
  input  logic [31:0]      pc_faulty,
  input  logic [31:0]      result_faulty,
  output logic             busy,
  output logic             done,
  output logic             fault_detected,
  output logic [1:0]       verdict,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_cycle,
  output logic [31:0]      first_pc,
  output logic [31:0]      first_result_golden,
  output logic [31:0]      first_result_faulty
`ifdef FAULT_MON_LOG_EN
  ,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [CNT_W+33:0] log_data,
  output logic             log_overflow
`endif
);

  if (MAX_CYCLES < 1 || longint'(MAX_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_max
    $error("MAX_CYCLES must be in 1..2**CNT_W");
  end
  if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("LOG_DEPTH must be a power of 2");
  end

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  verdict_e         verdict_q, verdict_d;
  verdict_e         cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] first_cycle_q, first_cycle_d;
  logic             fd_q, fd_d;
  logic [31:0]      first_pc_q, first_pc_d;
  logic [31:0]      first_rg_q, first_rg_d;
  logic [31:0]      first_rf_q, first_rf_d;

  logic pc_mis, res_mis, mismatch;

  assign pc_mis   = (pc_golden != pc_faulty);
  assign res_mis  = (result_golden != result_faulty);
  assign mismatch = pc_mis | res_mis;

  // NOTE: blocking assignments here on purpose: every _d gets its default
  // first (no latches), and later lines may read the updated fd_d/cause_d
  // so the terminating sample is latched before the verdict is formed.
  always_comb begin
    state_d       = state_q;
    verdict_d     = verdict_q;
    cause_d       = cause_q;
    cycle_d       = cycle_q;
    count_d       = count_q;
    first_cycle_d = first_cycle_q;
    fd_d          = fd_q;
    first_pc_d    = first_pc_q;
    first_rg_d    = first_rg_q;
    first_rf_d    = first_rf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          verdict_d     = V_NONE;
          cause_d       = V_NONE;
          cycle_d       = '0;
          count_d       = '0;
          first_cycle_d = '0;
          fd_d          = 1'b0;
          first_pc_d    = '0;
          first_rg_d    = '0;
          first_rf_d    = '0;
        end
      end
      RUN: begin
        cycle_d = cycle_q + 1'b1;
        if (mismatch) begin
          if (count_q != '1) count_d = count_q + 1'b1;
          if (!fd_q) begin
            fd_d          = 1'b1;
            first_cycle_d = cycle_q;
            first_pc_d    = pc_golden;
            first_rg_d    = result_golden;
            first_rf_d    = result_faulty;
            cause_d       = pc_mis ? V_CFE : V_SDC;
          end
        end
        if (cycle_q == LAST_K || (STOP_ON_FIRST != 0 && mismatch)) begin
          state_d   = DONE;
          verdict_d = fd_d ? cause_d : V_MASKED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      verdict_q     <= V_NONE;
      cause_q       <= V_NONE;
      cycle_q       <= '0;
      count_q       <= '0;
      first_cycle_q <= '0;
      fd_q          <= 1'b0;
      first_pc_q    <= '0;
      first_rg_q    <= '0;
      first_rf_q    <= '0;
    end else begin
      state_q       <= state_d;
      verdict_q     <= verdict_d;
      cause_q       <= cause_d;
      cycle_q       <= cycle_d;
      count_q       <= count_d;
      first_cycle_q <= first_cycle_d;
      fd_q          <= fd_d;
      first_pc_q    <= first_pc_d;
      first_rg_q    <= first_rg_d;
      first_rf_q    <= first_rf_d;
    end
  end

  assign busy                = (state_q == RUN);
  assign done                = (state_q == DONE);
  assign fault_detected      = fd_q;
  assign verdict             = verdict_q;
  assign mismatch_count      = count_q;
  assign first_cycle         = first_cycle_q;
  assign first_pc            = first_pc_q;
  assign first_result_golden = first_rg_q;
  assign first_result_faulty = first_rf_q;

`ifdef FAULT_MON_LOG_EN
  log_entry_t log_entry;
  logic       log_push, log_clr;

  assign log_entry = '{pc_mis: pc_mis, res_mis: res_mis, pc_faulty: pc_faulty};
  assign log_push  = (state_q == RUN) && mismatch;
  // Only a start that is actually accepted flushes the log.
  assign log_clr   = start && (state_q != RUN);

  mismatch_log_fifo #(
    .WIDTH (CNT_W + 34),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk       (clk),
    .rst       (rst),
    .clr       (log_clr),
    .push      (log_push),
    .push_data ({cycle_q, log_entry}),
    .ready     (log_ready),
    .valid     (log_valid),
    .data      (log_data),
    .overflow  (log_overflow)
  );
`endif

endmodule

// File: tb/tb_fault_divergence_monitor.sv
// Self-checking bench for fault_divergence_monitor. Three instances share
// the stimulus: A (runs to MAX_CYCLES=16), S (STOP_ON_FIRST=1) and
// C (CNT_W=4, saturating counter). A table of directed streams plus
// random streams are checked against a stream-level reference model.
module tb_fault_divergence_monitor;

  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] pcg, rg, pcf, rf;

  logic        busy_a, done_a, fd_a, busy_s, done_s, fd_s, busy_c, done_c, fd_c;
  logic [1:0]  verdict_a, verdict_s, verdict_c;
  logic [15:0] cnt_a, fc_a, cnt_s, fc_s;
  logic [3:0]  cnt_c, fc_c;
  logic [31:0] fpc_a, frg_a, frf_a, fpc_s, frg_s, frf_s, fpc_c, frg_c, frf_c;
`ifdef FAULT_MON_LOG_EN
  logic        log_ready;
  logic        lv_a, lo_a, lv_s, lo_s, lv_c, lo_c;
  logic [49:0] ld_a, ld_s;
  logic [37:0] ld_c;
`endif

  always #5 clk = ~clk;

  fault_divergence_monitor #(.CNT_W(16), .MAX_CYCLES(NS), .STOP_ON_FIRST(0)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .pc_golden(pcg), .result_golden(rg), .pc_faulty(pcf), .result_faulty(rf),
    .busy(busy_a), .done(done_a), .fault_detected(fd_a), .verdict(verdict_a),
    .mismatch_count(cnt_a), .first_cycle(fc_a), .first_pc(fpc_a),
    .first_result_golden(frg_a), .first_result_faulty(frf_a)
`ifdef FAULT_MON_LOG_EN
    , .log_valid(lv_a), .log_ready(log_ready), .log_data(ld_a), .log_overflow(lo_a)
`endif
  );

  fault_divergence_monitor #(.CNT_W(16), .MAX_CYCLES(NS), .STOP_ON_FIRST(1)) dut_s (
    .clk(clk), .rst(rst), .start(start),
    .pc_golden(pcg), .result_golden(rg), .pc_faulty(pcf), .result_faulty(rf),
    .busy(busy_s), .done(done_s), .fault_detected(fd_s), .verdict(verdict_s),
    .mismatch_count(cnt_s), .first_cycle(fc_s), .first_pc(fpc_s),
    .first_result_golden(frg_s), .first_result_faulty(frf_s)
`ifdef FAULT_MON_LOG_EN
    , .log_valid(lv_s), .log_ready(log_ready), .log_data(ld_s), .log_overflow(lo_s)
`endif
  );

  fault_divergence_monitor #(.CNT_W(4), .MAX_CYCLES(NS), .STOP_ON_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .start(start),
    .pc_golden(pcg), .result_golden(rg), .pc_faulty(pcf), .result_faulty(rf),
    .busy(busy_c), .done(done_c), .fault_detected(fd_c), .verdict(verdict_c),
    .mismatch_count(cnt_c), .first_cycle(fc_c), .first_pc(fpc_c),
    .first_result_golden(frg_c), .first_result_faulty(frf_c)
`ifdef FAULT_MON_LOG_EN
    , .log_valid(lv_c), .log_ready(log_ready), .log_data(ld_c), .log_overflow(lo_c)
`endif
  );

  // Current stream, one entry per sample index k.
  logic [31:0] s_pg[NS], s_pf[NS], s_rg[NS], s_rf[NS];

  typedef struct {
    bit          fd;
    int          verdict;
    int          cnt;
    int          first;
    logic [31:0] fpc, frg, frf;
    int          stop_k;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] pc_mask;
    logic [15:0] res_mask;
    int          verdict;
    int          cnt;
    int          first;
    bit          fd;
    logic [31:0] frg, frf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: walks the whole stream applying the classification
  // rules directly; sat is the counter ceiling.
  function automatic exp_t model(input bit stop, input int sat);
    exp_t e;
    int   n = 0;
    e = '{fd: 0, verdict: 1, cnt: 0, first: 0, fpc: 0, frg: 0, frf: 0, stop_k: NS - 1};
    for (int k = 0; k < NS; k++) begin
      bit pm = (s_pg[k] != s_pf[k]);
      bit rm = (s_rg[k] != s_rf[k]);
      if (pm || rm) begin
        n++;
        if (!e.fd) begin
          e.fd = 1; e.first = k; e.fpc = s_pg[k]; e.frg = s_rg[k]; e.frf = s_rf[k];
          e.verdict = pm ? 3 : 2;
        end
        if (stop) begin
          e.stop_k = k;
          break;
        end
      end
    end
    e.cnt = (n > sat) ? sat : n;
    return e;
  endfunction

  function automatic void fill_masked(input logic [15:0] pm, input logic [15:0] rm);
    for (int k = 0; k < NS; k++) begin
      s_pg[k] = 32'h1000 + 32'(4 * k);
      s_pf[k] = s_pg[k] ^ (pm[k] ? 32'h40 : 32'h0);
      s_rg[k] = 32'h5 + 32'(k);
      s_rf[k] = s_rg[k] ^ (rm[k] ? 32'h1 : 32'h0);
    end
  endfunction

  task automatic drive(input int k);
    pcg = s_pg[k]; pcf = s_pf[k]; rg = s_rg[k]; rf = s_rf[k];
  endtask

  // Full run of NS samples with per-sample progress checks.
  task automatic run_stream(input bit mid_start);
    exp_t es = model(1, 65535);
    int   run_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      drive(k);
      start = (mid_start && k == 4);
      step();
      if (s_pg[k] != s_pf[k] || s_rg[k] != s_rf[k]) run_cnt++;
      check("run_count_a", cnt_a, run_cnt);
      check("busy_a", busy_a, k < NS - 1);
      check("done_a", done_a, k == NS - 1);
      check("done_s", done_s, k >= es.stop_k);
    end
    start = 1'b0;
    pcg = '0; pcf = '0; rg = '0; rf = '0;
  endtask

  task automatic check_final();
    exp_t ea = model(0, 65535);
    exp_t es = model(1, 65535);
    exp_t ec = model(0, 15);
    check("a_fd", fd_a, ea.fd);          check("a_verdict", verdict_a, ea.verdict);
    check("a_count", cnt_a, ea.cnt);     check("a_first_cycle", fc_a, ea.first);
    check("a_first_pc", fpc_a, ea.fpc);  check("a_first_rg", frg_a, ea.frg);
    check("a_first_rf", frf_a, ea.frf);
    check("s_done", done_s, 1);          check("s_verdict", verdict_s, es.verdict);
    check("s_count", cnt_s, es.cnt);     check("s_first_cycle", fc_s, es.first);
    check("s_first_pc", fpc_s, es.fpc);
    check("c_count", cnt_c, ec.cnt);     check("c_verdict", verdict_c, ec.verdict);
    check("c_first_cycle", fc_c, ec.first);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"identical",   16'h0000, 16'h0000, 1, 0,  0,  0, 32'h0,  32'h0};
    tbl[1] = '{"res_at_5",    16'h0000, 16'h0020, 2, 1,  5,  1, 32'hA,  32'hB};
    tbl[2] = '{"pc_from_3",   16'hFFF8, 16'h0000, 3, 13, 3,  1, 32'h8,  32'h8};
    tbl[3] = '{"both_at_2",   16'h0004, 16'h0004, 3, 1,  2,  1, 32'h7,  32'h6};
    tbl[4] = '{"res_every",   16'h0000, 16'hFFFF, 2, 16, 0,  1, 32'h5,  32'h4};
    tbl[5] = '{"res_last",    16'h0000, 16'h8000, 2, 1,  15, 1, 32'h14, 32'h15};

    rst = 1'b1; start = 1'b0;
    pcg = '0; pcf = '0; rg = '0; rf = '0;
`ifdef FAULT_MON_LOG_EN
    log_ready = 1'b1;
`endif
    step(); step();
    rst = 1'b0;
    check("reset_busy", busy_a, 0);    check("reset_done", done_a, 0);
    check("reset_fd", fd_a, 0);        check("reset_verdict", verdict_a, 0);
    check("reset_count", cnt_a, 0);    check("reset_first_pc", fpc_a, 0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      fill_masked(tbl[i].pc_mask, tbl[i].res_mask);
      run_stream(0);
      check({tbl[i].name, "_verdict"}, verdict_a, tbl[i].verdict);
      check({tbl[i].name, "_count"}, cnt_a, tbl[i].cnt);
      check({tbl[i].name, "_first"}, fc_a, tbl[i].first);
      check({tbl[i].name, "_fd"}, fd_a, tbl[i].fd);
      check({tbl[i].name, "_frg"}, frg_a, tbl[i].frg);
      check({tbl[i].name, "_frf"}, frf_a, tbl[i].frf);
      check_final();
    end

    // Random streams against the model.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NS; k++) begin
        s_pg[k] = $urandom;
        s_rg[k] = $urandom;
        s_pf[k] = ($urandom_range(0, 9) == 0) ? (s_pg[k] ^ ($urandom | 32'h1)) : s_pg[k];
        s_rf[k] = ($urandom_range(0, 5) == 0) ? (s_rg[k] ^ ($urandom | 32'h1)) : s_rg[k];
      end
      run_stream(0);
      check_final();
    end

    // Reset mid-run after a PC divergence, then a clean run with a
    // start pulse inside RUN that must be ignored.
    fill_masked(16'hFFFC, 16'h0000);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(k);
      step();
    end
    check("pre_rst_fd", fd_a, 1);
    drive(7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy_a, 0);    check("abort_done", done_a, 0);
    check("abort_fd", fd_a, 0);        check("abort_verdict", verdict_a, 0);
    check("abort_count", cnt_a, 0);    check("abort_first_cycle", fc_a, 0);
    check("abort_first_pc", fpc_a, 0); check("abort_done_s", done_s, 0);
    fill_masked(16'h0000, 16'h0000);
    run_stream(1);
    check("clean_verdict", verdict_a, 1);
    check_final();

`ifdef FAULT_MON_LOG_EN
    // Ten mismatches (k=0..9) into an 8-deep log with no consumer.
    fill_masked(16'h0000, 16'h03FF);
    log_ready = 1'b0;
    run_stream(0);
    check_final();
    check("log_overflow", lo_a, 1);
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("log_valid", lv_a, 1);
      check("log_k", ld_a[49:34], i);
      check("log_res_mis", ld_a[32], 1);
      check("log_pc_mis", ld_a[33], 0);
      step();
    end
    check("log_empty", lv_a, 0);
    start = 1'b1; step(); start = 1'b0;
    check("log_ovf_cleared", lo_a, 0);
    step(); step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
